lcd1602_responder: RTL

LCD1602_RESPONDER -- requirements
Module: lcd1602_responder

---
 rtl/lcd1602_responder.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/lcd1602_responder.sv
// HD44780-style LCD1602 bus responder: synchronises the controller bus, decodes
// writes into a 32-cell display model, and reports status, events and errors.
module lcd1602_responder #(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rs,
    input  logic       rw,
    input  logic       enable,
    input  logic [7:0] data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] cur_addr,
    output logic       busy,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       cg_mode,
    output logic       func_ok,
    output logic       evt_valid,
    output logic       evt_rs,
    output logic [7:0] evt_data,
    output logic       overrun,
    output logic       rd_attempt
);

    // Bus bundle order: {rs, rw, enable, data}
    logic [10:0] sync1_r;
    logic [10:0] sync2_r;
    logic        en_prev_r;

    logic        rs_s;
    logic        rw_s;
    logic        en_s;
    logic [7:0]  data_s;
    logic        fall_s;
    logic        wr_s;
    logic        long_s;
    logic        cell_hit_s;
    logic [4:0]  cell_idx_s;

    logic [31:0] busy_cnt_r;
    logic [5:0]  cg_addr_r;
    logic        id_r;
    logic [31:0] blank_r;
    logic [7:0]  cells_r [0:31];

    assign rs_s   = sync2_r[10];
    assign rw_s   = sync2_r[9];
    assign en_s   = sync2_r[8];
    assign data_s = sync2_r[7:0];
    assign fall_s = en_prev_r & ~en_s;
    assign wr_s   = fall_s & ~rw_s;
    // Clear (0x01) and home (0x02/0x03) take the long busy time.
    assign long_s = ~rs_s & (data_s[7:2] == 6'd0) & (data_s[1:0] != 2'd0);

    // DDRAM line 1 is 0x00-0x0F, line 2 is 0x40-0x4F; other AC values are off-screen.
    assign cell_hit_s = (cur_addr[6:4] == 3'b000) | (cur_addr[6:4] == 3'b100);
    assign cell_idx_s = {cur_addr[6], cur_addr[3:0]};

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h27) begin
                r = 7'h40;
            end else if (a == 7'h67) begin
                r = 7'h00;
            end else begin
                r = a + 7'd1;
            end
        end else begin
            if (a == 7'h00) begin
                r = 7'h67;
            end else if (a == 7'h40) begin
                r = 7'h27;
            end else begin
                r = a - 7'd1;
            end
        end
        return r;
    endfunction

    // Two-flop synchroniser for the whole bus plus enable history for edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r   <= 11'd0;
            sync2_r   <= 11'd0;
            en_prev_r <= 1'b0;
        end else begin
            sync1_r   <= {rs, rw, enable, data};
            sync2_r   <= sync1_r;
            en_prev_r <= en_s;
        end
    end

    // Busy counter: reloads on every accepted write, even one arriving while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_cnt_r <= 32'd0;
            busy       <= 1'b0;
        end else if (wr_s) begin
            busy_cnt_r <= long_s ? 32'(CLEAR_CYCLES) : 32'(BUSY_CYCLES);
            busy       <= long_s ? (CLEAR_CYCLES != 0) : (BUSY_CYCLES != 0);
        end else if (busy_cnt_r != 32'd0) begin
            busy_cnt_r <= busy_cnt_r - 32'd1;
            busy       <= (busy_cnt_r != 32'd1);
        end else begin
            busy_cnt_r <= 32'd0;
            busy       <= 1'b0;
        end
    end

    // Transaction decode: command/data execution, events and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_addr   <= 7'd0;
            cg_addr_r  <= 6'd0;
            id_r       <= 1'b1;
            cg_mode    <= 1'b0;
            disp_on    <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            func_ok    <= 1'b0;
            evt_valid  <= 1'b0;
            evt_rs     <= 1'b0;
            evt_data   <= 8'h00;
            overrun    <= 1'b0;
            rd_attempt <= 1'b0;
            blank_r    <= {32{1'b1}};
            for (int i = 0; i < 32; i++) begin
                cells_r[i] <= 8'h20;
            end
        end else begin
            evt_valid <= 1'b0;
            if (fall_s && rw_s) begin
                rd_attempt <= 1'b1;
            end else if (wr_s) begin
                evt_valid <= 1'b1;
                evt_rs    <= rs_s;
                evt_data  <= data_s;
                if (busy) begin
                    overrun <= 1'b1;
                end else begin
                    overrun <= overrun;
                end
                if (!rs_s) begin
                    casez (data_s)
                        8'b1???????: begin
                            cur_addr <= data_s[6:0];
                            cg_mode  <= 1'b0;
                        end
                        8'b01??????: begin
                            cg_addr_r <= data_s[5:0];
                            cg_mode   <= 1'b1;
                        end
                        8'b001?????: func_ok <= (data_s == 8'h38);
                        8'b0001????: begin
                            if (!data_s[3]) begin
                                cur_addr <= ac_step(cur_addr, data_s[2]);
                            end else begin
                                cur_addr <= cur_addr;
                            end
                        end
                        8'b00001???: begin
                            disp_on   <= data_s[2];
                            cursor_on <= data_s[1];
                            blink_on  <= data_s[0];
                        end
                        8'b000001??: id_r <= data_s[1];
                        8'b0000001?: begin
                            cur_addr <= 7'd0;
                            cg_mode  <= 1'b0;
                        end
                        8'b00000001: begin
                            blank_r  <= {32{1'b1}};
                            cur_addr <= 7'd0;
                            id_r     <= 1'b1;
                            cg_mode  <= 1'b0;
                        end
                        default: begin
                            cur_addr <= cur_addr;
                        end
                    endcase
                end else if (cg_mode) begin
                    cg_addr_r <= id_r ? (cg_addr_r + 6'd1) : (cg_addr_r - 6'd1);
                end else begin
                    if (cell_hit_s) begin
                        cells_r[cell_idx_s] <= data_s;
                        blank_r[cell_idx_s] <= 1'b0;
                    end else begin
                        blank_r <= blank_r;
                    end
                    cur_addr <= ac_step(cur_addr, id_r);
                end
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

    // Blanked cells read as space regardless of stale storage contents.
    always_comb begin
        if (blank_r[rd_addr]) begin
            rd_data = 8'h20;
        end else begin
            rd_data = cells_r[rd_addr];
        end
    end

endmodule
